fifo_burst_reader: RTL and testbench

//   Read-side consumer for the 8-bit synchronous FIFO. Pops bytes using the FIFO's
//   rd_en/empty/count handshake and forwards them on a valid/ready stream, grouped

---
 rtl/fifo_burst_reader.sv | 97 +++++++++
 tb/tb_fifo_burst_reader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops bytes from a FIFO and sends them downstream as valid/ready bursts with m_last
module fifo_burst_reader #(
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 7,
    parameter int BURST_LEN = 16,
    parameter int TIMEOUT   = 255,
    parameter int TMO_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [CNT_W-1:0]  fifo_count,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic [15:0]       burst_cnt
);
    typedef enum logic [1:0] {IDLE, READ, CAPTURE, SEND} state_t;
    state_t              state_q, state_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic                m_valid_q, m_valid_d;
    logic                m_last_q, m_last_d;
    logic [15:0]         burst_cnt_q, burst_cnt_d;
    logic                full, start;
    assign full  = fifo_count >= CNT_W'(BURST_LEN);
    assign start = enable && (full || tmo_cnt_q == TMO_W'(TIMEOUT));
    always_comb begin
        state_d     = state_q;
        tmo_cnt_d   = tmo_cnt_q;
        remaining_d = remaining_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = READ;
                    tmo_cnt_d   = '0;
                    remaining_d = full ? CNT_W'(BURST_LEN) : fifo_count;
                end else begin
                    tmo_cnt_d = (!enable || fifo_empty) ? '0 :
                                (tmo_cnt_q != TMO_W'(TIMEOUT)) ? tmo_cnt_q + TMO_W'(1) : tmo_cnt_q;
                end
            end
            READ: state_d = fifo_empty ? READ : CAPTURE;
            CAPTURE: begin
                m_data_d  = fifo_dout;
                m_valid_d = 1'b1;
                m_last_d  = remaining_q == CNT_W'(1);
                state_d   = SEND;
            end
            SEND: begin
                if (m_valid_q && m_ready) begin
                    m_valid_d   = 1'b0;
                    m_last_d    = 1'b0;
                    remaining_d = remaining_q - CNT_W'(1);
                    burst_cnt_d = (remaining_q == CNT_W'(1)) ? burst_cnt_q + 16'd1 : burst_cnt_q;
                    state_d     = (remaining_q == CNT_W'(1)) ? IDLE : READ;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tmo_cnt_q   <= '0;
            remaining_q <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tmo_cnt_q   <= tmo_cnt_d;
            remaining_q <= remaining_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end
    assign fifo_rd_en = (state_q == READ) && !fifo_empty;
    assign busy       = state_q != IDLE;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_last     = m_last_q;
    assign burst_cnt  = burst_cnt_q;
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: randomized and directed bench with a queue-based FIFO and burst scoreboard
module tb_fifo_burst_reader;
    localparam int BL  = 16;
    localparam int TMO = 255;
    logic        clk = 1'b0;
    logic        rst, enable, m_ready, fifo_rd_en, m_valid, m_last, busy;
    logic        fifo_empty = 1'b1;
    logic [6:0]  fifo_count = '0;
    logic [7:0]  fifo_dout = '0;
    logic [7:0]  m_data;
    logic [15:0] burst_cnt;
    logic        push_en = 1'b0, fifo_rst = 1'b0;
    logic [7:0]  push_data = '0;
    logic [7:0]  fq[$];
    logic [7:0]  exp_q[$];
    int          tests = 0, fails = 0;
    int          wait_cnt = 0, bsize = 0, bidx = 0, hs = 0, pops = 0, prev_count = 0;
    logic        prev_busy = 1'b0, prev_idle = 1'b0, prev_hold = 1'b0, exp_start = 1'b0, prev_last = 1'b0;
    logic [7:0]  prev_data = '0;

    fifo_burst_reader dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
        .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .busy(busy), .burst_cnt(burst_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_byte(input logic [7:0] d);
        push_en   = 1'b1;
        push_data = d;
        exp_q.push_back(d);
        step(1);
        push_en = 1'b0;
    endtask

    task automatic wait_bursts(input int target, input int budget);
        int n = 0;
        while (burst_cnt != 16'(target) && n < budget) begin
            step(1);
            n++;
        end
        check("burst_cnt", 32'(burst_cnt), 32'(target));
    endtask

    // Behavioural FIFO with registered read data
    always @(posedge clk) begin
        if (fifo_rst) begin
            fq.delete();
            fifo_dout <= '0;
        end else begin
            if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
            if (push_en) fq.push_back(push_data);
        end
        fifo_count <= 7'(fq.size());
        fifo_empty <= fq.size() == 0;
    end

    // Scoreboard and burst-rule model, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            wait_cnt = 0; prev_busy = 0; prev_idle = 0; prev_hold = 0;
            hs = 0; pops = 0; bidx = 0; bsize = 0; prev_count = 0;
        end else begin
            if (prev_idle) check("start_rule", 32'(busy), 32'(exp_start));
            if (busy && !prev_busy) begin
                bsize = prev_count < BL ? prev_count : BL;
                bidx  = 0;
            end
            if (prev_hold) begin
                check("hold_valid", 32'(m_valid), 32'(1));
                check("hold_data", 32'(m_data), 32'(prev_data));
                check("hold_last", 32'(m_last), 32'(prev_last));
            end
            if (fifo_rd_en) begin
                pops++;
                check("rd_en_ctx", 32'(busy && !m_valid), 32'(1));
            end
            if (m_valid && m_ready) begin
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) begin
                    check("m_data", 32'(m_data), 32'(exp_q.pop_front()));
                    check("m_last", 32'(m_last), 32'(bidx + 1 == bsize));
                end
                bidx++;
                hs++;
            end
            exp_start = enable && (fifo_count >= 7'(BL) || wait_cnt == TMO);
            prev_idle = !busy;
            wait_cnt  = (busy || exp_start || !enable || fifo_empty) ? 0 :
                        (fifo_count < 7'(BL) && wait_cnt < TMO) ? wait_cnt + 1 : wait_cnt;
            prev_hold  = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            prev_busy  = busy;
            prev_count = int'(fifo_count);
        end
    end

    initial begin
        int n, base;
        rst = 1'b1; enable = 1'b1; m_ready = 1'b1;
        step(1);
        // Reset held while the FIFO fills with a full burst
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        check("rst_m_valid", 32'(m_valid), 32'(0));
        check("rst_rd_en", 32'(fifo_rd_en), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_burst_cnt", 32'(burst_cnt), 32'(0));
        check("rst_m_data", 32'(m_data), 32'(0));
        check("rst_m_last", 32'(m_last), 32'(0));
        rst = 1'b0;
        wait_bursts(1, 200);
        check("full_pops", 32'(pops), 32'(16));
        check("full_empty", 32'(fifo_count), 32'(0));
        // Partial burst after timeout
        base = pops;
        for (int i = 0; i < 5; i++) push_byte(8'hA0 + 8'(i));
        step(248);
        check("tmo_no_rd", 32'(pops), 32'(base));
        wait_bursts(2, 400);
        check("tmo_pops", 32'(pops), 32'(base + 5));
        // Backpressure
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) push_byte(8'($urandom));
        n = 0;
        while (!m_valid && n < 100) begin step(1); n++; end
        check("bp_valid", 32'(m_valid), 32'(1));
        base = pops;
        step(10);
        check("bp_no_rd", 32'(pops), 32'(base));
        check("bp_still_valid", 32'(m_valid), 32'(1));
        m_ready = 1'b1;
        wait_bursts(3, 300);
        // Enable gating
        enable = 1'b0;
        base = pops;
        for (int i = 0; i < 20; i++) push_byte(8'h40 + 8'(i));
        step(300);
        check("gate_no_rd", 32'(pops), 32'(base));
        enable = 1'b1;
        wait_bursts(5, 1000);
        check("gate_pops", 32'(pops), 32'(base + 20));
        check("gate_empty", 32'(fifo_count), 32'(0));
        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            enable  = ((c / 250) % 4) != 3;
            m_ready = $urandom_range(0, 3) != 0;
            if (fifo_count < 7'd56 && $urandom_range(0, 2) == 0) begin
                push_en   = 1'b1;
                push_data = 8'($urandom);
                exp_q.push_back(push_data);
            end else push_en = 1'b0;
            step(1);
        end
        push_en = 1'b0; enable = 1'b1; m_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 5000) begin step(1); n++; end
        check("drain_sb", 32'(exp_q.size()), 32'(0));
        check("drain_pops", 32'(pops), 32'(hs));
        check("drain_fifo", 32'(fifo_count), 32'(0));
        // Reset mid-burst
        for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i));
        base = hs;
        n = 0;
        while (hs < base + 3 && n < 200) begin step(1); n++; end
        check("mid_hs", 32'(hs), 32'(base + 3));
        rst = 1'b1; fifo_rst = 1'b1;
        step(1);
        check("mid_busy", 32'(busy), 32'(0));
        check("mid_m_valid", 32'(m_valid), 32'(0));
        check("mid_m_data", 32'(m_data), 32'(0));
        check("mid_m_last", 32'(m_last), 32'(0));
        check("mid_rd_en", 32'(fifo_rd_en), 32'(0));
        check("mid_burst_cnt", 32'(burst_cnt), 32'(0));
        rst = 1'b0; fifo_rst = 1'b0;
        exp_q.delete();
        step(20);
        check("post_idle", 32'(busy), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
